// File: rtl/bit_shaper_pkg.sv
// ============================================================================
// Module  : bit_shaper_pkg
// Brief   : Shared types, funct codes and state encodings for bit_shaper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package bit_shaper_pkg;

  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 4;
  localparam int SHAMT_W = 6;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [FUNCT_W-1:0] funct_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  localparam funct_t FUNCT_SHP_SLL    = 4'd0;
  localparam funct_t FUNCT_SHP_SRL    = 4'd1;
  localparam funct_t FUNCT_SHP_SRA    = 4'd2;
  localparam funct_t FUNCT_SHP_LZMASK = 4'd3;
  localparam funct_t FUNCT_SHP_LOMASK = 4'd4;

  localparam data_t  ZERO_WORD = '0;
  localparam data_t  ONES_WORD = '1;
  localparam shamt_t SHAMT_MAX = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic shamt_t clamp_amount(input shamt_t a);
    return (a > SHAMT_MAX) ? SHAMT_MAX : a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_shaper_if.sv
// ============================================================================
// Module  : bit_shaper_if
// Brief   : Request/response bundle between the EX stage and bit_shaper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface bit_shaper_if;
  import bit_shaper_pkg::*;

  logic   start;
  logic   flush;
  funct_t funct;
  data_t  operand;
  shamt_t amount;
  logic   busy;
  logic   done;
  data_t  result;

  modport master (
    output start, flush, funct, operand, amount,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct, operand, amount,
    output busy, done, result
  );

endinterface

`default_nettype wire

// File: rtl/bit_shaper_shift_stage.sv
// ============================================================================
// Module  : shift_stage
// Brief   : One combinational stage of the log shifter, shift by 2^weight.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module shift_stage #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      enable,
  input  logic                      shift_left,
  input  logic                      fill,
  input  logic [$clog2(STAGES)-1:0] weight,
  output logic [WIDTH-1:0]          data_out
);

  logic [31:0]      sh_amt;
  logic [WIDTH-1:0] fill_mask;

  always_comb begin
    sh_amt    = 32'd1 << weight;
    // Vacated upper bits on a right shift take the fill bit.
    fill_mask = fill ? ~({WIDTH{1'b1}} >> sh_amt) : '0;
    data_out  = data_in;
    if (enable) begin
      if (shift_left) data_out = data_in << sh_amt;
      else            data_out = (data_in >> sh_amt) | fill_mask;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bit_shaper.sv
// ============================================================================
// Module  : bit_shaper
// Brief   : Multi-cycle shifter / leading-mask generator, one stage per cycle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bit_shaper
  import bit_shaper_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic         clk,
  input  logic         rst,
  bit_shaper_if.slave  bus
);

  localparam int CNT_W = $clog2(STAGES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  stage_q, stage_d;
  data_t             work_q, work_d;
  data_t             result_q, result_d;
  funct_t            funct_q, funct_d;
  shamt_t            n_q, n_d;
  logic              fill_q, fill_d;

  logic              accept;
  logic              fill_in;
  shamt_t            n_in;
  data_t             load_word;
  data_t             stage_out;

  shift_stage #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_stage (
    .data_in    (work_q),
    .enable     (n_q[stage_q]),
    .shift_left (funct_q == FUNCT_SHP_SLL),
    .fill       (fill_q),
    .weight     (stage_q),
    .data_out   (stage_out)
  );

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    work_d   = work_q;
    result_d = result_q;
    funct_d  = funct_q;
    n_d      = n_q;
    fill_d   = fill_q;

    accept    = bus.start && !bus.flush && (state_q != ST_SHIFT);
    n_in      = clamp_amount(bus.amount);
    fill_in   = (bus.funct == FUNCT_SHP_SRA) && bus.operand[WIDTH-1];
    load_word = ((bus.funct == FUNCT_SHP_LZMASK) || (bus.funct == FUNCT_SHP_LOMASK))
                ? ONES_WORD : bus.operand;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_SHIFT;
          stage_d = CNT_W'(STAGES - 1);
          funct_d = bus.funct;
          n_d     = n_in;
          fill_d  = fill_in;
          // A full-width shift is resolved at load; the stages then run as no-ops.
          work_d  = (n_in == SHAMT_MAX) ? {WIDTH{fill_in}} : load_word;
        end
      end
      ST_SHIFT: begin
        work_d = stage_out;
        if (stage_q == '0) begin
          state_d = ST_DONE;
          case (funct_q)
            FUNCT_SHP_SLL, FUNCT_SHP_SRL,
            FUNCT_SHP_SRA, FUNCT_SHP_LZMASK: result_d = stage_out;
            FUNCT_SHP_LOMASK:                result_d = ~stage_out;
            default:                         result_d = ZERO_WORD;
          endcase
        end else begin
          stage_d = stage_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      work_q   <= '0;
      result_q <= '0;
      funct_q  <= '0;
      n_q      <= '0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      work_q   <= work_d;
      result_q <= result_d;
      funct_q  <= funct_d;
      n_q      <= n_d;
      fill_q   <= fill_d;
    end
  end

  assign bus.busy   = (state_q == ST_SHIFT);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_shaper.sv
// ============================================================================
// Module  : tb_bit_shaper
// Brief   : Self-checking bench for bit_shaper against a behavioural model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_bit_shaper;
  import bit_shaper_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bit_shaper_if bif();

  bit_shaper #(
    .WIDTH  (32),
    .STAGES (5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  function automatic data_t model(input funct_t f, input data_t op, input shamt_t a);
    int unsigned n;
    n = (a > 32) ? 32 : int'(a);
    case (f)
      FUNCT_SHP_SLL:    return op << n;
      FUNCT_SHP_SRL:    return op >> n;
      FUNCT_SHP_SRA:    return data_t'($signed(op) >>> n);
      FUNCT_SHP_LZMASK: return 32'hFFFF_FFFF >> n;
      FUNCT_SHP_LOMASK: return ~(32'hFFFF_FFFF >> n);
      default:          return 32'h0;
    endcase
  endfunction

  function automatic int clz(input data_t w);
    for (int i = 31; i >= 0; i--) if (w[i]) return 31 - i;
    return 32;
  endfunction

  task automatic issue(input funct_t f, input data_t op, input shamt_t a);
    bif.funct   = f;
    bif.operand = op;
    bif.amount  = a;
    bif.start   = 1'b1;
    @(posedge clk); #1;
    bif.start   = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = -1;
    bcnt = bif.busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bif.done) begin
        cyc = i;
        break;
      end
      if (bif.busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    bif.start = 0; bif.flush = 0; bif.funct = '0; bif.operand = '0; bif.amount = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", bif.done); end
    checks++; if (bif.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h exp 0", bif.result); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sra_timing();
    int c, b;
    issue(FUNCT_SHP_SRA, 32'h8000_0000, 6'd4);
    wait_done(c, b);
    checks++; if (c !== 5) begin errors++; $display("FAIL sra_latency: got %0d exp 5", c); end
    checks++; if (b !== 5) begin errors++; $display("FAIL sra_busy_cycles: got %0d exp 5", b); end
    checks++; if (bif.result !== 32'hF800_0000) begin errors++; $display("FAIL sra_result: got %h exp f8000000", bif.result); end
    @(posedge clk); #1;
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL sra_done_pulse: got %b exp 0", bif.done); end
  endtask

  task automatic test_masks();
    funct_t f[4]   = '{FUNCT_SHP_LOMASK, FUNCT_SHP_LZMASK, FUNCT_SHP_LOMASK, FUNCT_SHP_LZMASK};
    shamt_t a[4]   = '{6'd3, 6'd3, 6'd0, 6'd0};
    data_t  exp[4] = '{32'hE000_0000, 32'h1FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    int c, b;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], $urandom, a[i]);
      wait_done(c, b);
      checks++; if (c !== 5 || bif.result !== exp[i]) begin
        errors++; $display("FAIL mask_%0d: got %h lat %0d exp %h lat 5", i, bif.result, c, exp[i]);
      end
    end
  endtask

  task automatic test_clamp();
    funct_t f[4]   = '{FUNCT_SHP_SRL, FUNCT_SHP_SRL, FUNCT_SHP_SRA, FUNCT_SHP_SLL};
    data_t  op[4]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0001, 32'h0000_0001};
    shamt_t a[4]   = '{6'd32, 6'd40, 6'd40, 6'd31};
    data_t  exp[4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
    int c, b;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], op[i], a[i]);
      wait_done(c, b);
      checks++; if (c !== 5 || bif.result !== exp[i]) begin
        errors++; $display("FAIL clamp_%0d: got %h lat %0d exp %h lat 5", i, bif.result, c, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    funct_t f; data_t op; shamt_t a; data_t exp;
    int c, b;
    for (int i = 0; i < 40; i++) begin
      f  = funct_t'($urandom_range(0, 7));
      op = $urandom;
      a  = shamt_t'($urandom_range(0, 63));
      exp = model(f, op, a);
      issue(f, op, a);
      wait_done(c, b);
      checks++; if (c !== 5 || bif.result !== exp) begin
        errors++; $display("FAIL random_%0d f=%0d op=%h n=%0d: got %h lat %0d exp %h lat 5",
                           i, f, op, a, bif.result, c, exp);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_start_mid_shift();
    int ndone = 0;
    data_t r = '0;
    issue(FUNCT_SHP_SLL, 32'h0000_0001, 6'd7);
    @(posedge clk); #1;
    bif.funct = FUNCT_SHP_LOMASK; bif.amount = 6'd9; bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bif.done) begin ndone++; r = bif.result; end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL mid_start_dones: got %0d exp 1", ndone); end
    checks++; if (r !== 32'h0000_0080) begin errors++; $display("FAIL mid_start_result: got %h exp 00000080", r); end
  endtask

  task automatic test_back_to_back();
    int c, b;
    issue(FUNCT_SHP_SRL, 32'hF000_0000, 6'd4);
    wait_done(c, b);
    checks++; if (c !== 5 || bif.result !== 32'h0F00_0000) begin
      errors++; $display("FAIL b2b_first: got %h lat %0d exp 0f000000 lat 5", bif.result, c);
    end
    issue(FUNCT_SHP_LOMASK, 32'h0, 6'd12);
    checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL b2b_reload_busy: got %b exp 1", bif.busy); end
    wait_done(c, b);
    checks++; if (c !== 5 || bif.result !== 32'hFFF0_0000) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d exp fff00000 lat 5", bif.result, c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int c, b, ndone;
    data_t r;
    issue(FUNCT_SHP_SRL, 32'hDEAD_BEEF, 6'd8);
    wait_done(c, b);
    r = bif.result;
    checks++; if (r !== 32'h00DE_ADBE) begin errors++; $display("FAIL flush_setup: got %h exp 00deadbe", r); end
    @(posedge clk); #1;
    issue(FUNCT_SHP_LOMASK, 32'h0, 6'd5);
    @(posedge clk); #1;
    bif.flush = 1'b1;
    @(posedge clk); #1;
    bif.flush = 1'b0;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b exp 0", bif.busy); end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (bif.done) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL flush_no_done: got %0d exp 0", ndone); end
    checks++; if (bif.result !== 32'h00DE_ADBE) begin errors++; $display("FAIL flush_result_hold: got %h exp 00deadbe", bif.result); end
    bif.funct = FUNCT_SHP_SLL; bif.operand = 32'h1; bif.amount = 6'd1;
    bif.start = 1'b1; bif.flush = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0; bif.flush = 1'b0;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b exp 0", bif.busy); end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (bif.done) ndone++; end
    checks++; if (ndone !== 0 || bif.result !== 32'h00DE_ADBE) begin
      errors++; $display("FAIL flush_start_no_accept: got dones %0d result %h exp 0 00deadbe", ndone, bif.result);
    end
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    issue(FUNCT_SHP_SRA, 32'h8000_0000, 6'd2);
    @(posedge clk);
    #4 rst = 1'b1;
    #1;
    checks++; if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.result !== 32'h0) begin
      errors++; $display("FAIL async_reset: got busy %b done %b result %h exp 0 0 0", bif.busy, bif.done, bif.result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (bif.done) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL async_reset_no_done: got %0d exp 0", ndone); end
  endtask

  task automatic test_loopback();
    int c, b;
    for (int n = 0; n <= 32; n++) begin
      issue(FUNCT_SHP_LZMASK, $urandom, shamt_t'(n));
      wait_done(c, b);
      checks++; if (c !== 5 || clz(bif.result) !== n) begin
        errors++; $display("FAIL loopback_%0d: got clz %0d result %h lat %0d exp clz %0d lat 5",
                           n, clz(bif.result), bif.result, c, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sra_timing();
    test_masks();
    test_clamp();
    test_random();
    test_start_mid_shift();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/bit_shaper.md
# bit_shaper

Multi-cycle EX-stage unit that goes from a bit count to a data word, the inverse of the leading-zero/leading-one counter. It takes a count and produces either a shifted operand (SLL/SRL/SRA) or a mask with that many leading zeros or ones. The shift is a logarithmic shifter stepped one stage per cycle, with a start/busy/done handshake to the EX stall logic. It sits beside the ALU and bit counter and writes its result onto the EX result mux.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; only 32 is supported.
- `STAGES`, 5, log2(`WIDTH`), the number of shift stages.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `flush`  in  1  synchronous abort from pipeline flush.
- `funct`  in  `FUNCT_BUS`  operation select; sampled on accept.
- `operand`  in  `DATA_BUS`  data to shift; sampled on accept; ignored for the mask operations.
- `amount`  in  6  count; values 0..63, anything above 32 is treated as 32.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; `result` is valid while it is high.
- `result`  out  `DATA_BUS`  last completed result; holds until the next completion.

## Operation
- States: IDLE, SHIFT, DONE.
- On accept, capture:
  - `funct` and the clamped amount `n`.
  - Fill bit: `operand[31]` for SRA, 0 otherwise.
  - Work register: `operand` for SLL/SRL/SRA, 0xFFFFFFFF for LZMASK/LOMASK.
- If `n` = 32 at load, the work register is set to all fill bits immediately. The stages still run, so latency is fixed.
- Stage counter starts at 4 and counts down. In each SHIFT cycle the stage with weight 2^k shifts by 2^k when `n[k]` is set.
  - Direction: left for SLL; right for all other operations.
  - Right shifts insert the fill bit.
- After stage 0 the state goes to DONE and `result` is written:
  - SLL/SRL/SRA: the work register.
  - LZMASK: the work register, i.e. 0xFFFFFFFF >> n.
  - LOMASK: the inverted work register.
  - Any other `funct`: `ZERO_WORD`.
- DONE lasts exactly one cycle, then returns to IDLE, or reloads if `start` is high (back-to-back).
- `start` during SHIFT is ignored; no queueing.
- `flush`:
  - In any state: next state IDLE; `done` is not asserted; `result` is unchanged.
  - Has priority over `start` in the same cycle.
- Reset: state IDLE, stage counter 0, work register 0, `busy`=0, `done`=0, `result`=0.
- Reset mid-operation: the operation is lost with no pending completion.

## Timing
- Accept edge E: load happens; `busy`=1 from E.
- Edges E+1..E+5 apply stages 16, 8, 4, 2, 1.
- At E+5: `busy`=0, `done`=1, `result` is updated.
- At E+6: `done`=0.
- Latency: 5 cycles from accept to `done`. Throughput is one operation per 6 cycles, or per 5 cycles back-to-back via DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Add `FUNCT_SHP_SLL`, `FUNCT_SHP_SRL`, `FUNCT_SHP_SRA`, `FUNCT_SHP_LZMASK`, `FUNCT_SHP_LOMASK` to the shared funct definitions.
- Add the state encodings and a `SHAMT_BUS` width macro to the global definitions.
- One natural sub-module: `shift_stage`, a combinational single stage (data, enable, direction, fill, weight → data). It is instantiated once and muxed by the stage counter.

## Test plan
- SRA, operand 0x80000000, amount 4: `done` exactly at the 5th edge after accept; `result`=0xF8000000; `busy` high for 5 cycles.
- Masks:
  - LOMASK amount 3 → 0xE0000000.
  - LZMASK amount 3 → 0x1FFFFFFF.
  - LOMASK amount 0 → 0x00000000.
  - LZMASK amount 0 → 0xFFFFFFFF.
- Clamping:
  - SRL 0xDEADBEEF amounts 32 and 40 → 0.
  - SRA 0x80000001 amount 40 → 0xFFFFFFFF.
  - SLL 0x00000001 amount 31 → 0x80000000.
- Handshake:
  - `start` pulsed mid-SHIFT is ignored: one `done` only.
  - `start` during DONE reloads: next `done` 5 cycles later.
- `flush` at the 3rd SHIFT cycle: returns to IDLE, no `done`, `result` keeps its previous value.
  - `flush` and `start` in the same IDLE cycle: no accept.
- Assert `rst` asynchronously mid-SHIFT: all outputs go to 0 immediately and no `done` follows.
- Loopback check: for n in 0..32, run LZMASK and feed the result to the bit counter's CLZ; the CLZ result must equal n.
